// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: round-robin scan controller for a one-hot digit decoder.
// Each slot is PRESCALE cycles: (PRESCALE-BLANK) cycles with en=1, then BLANK
// cycles with en=0. The mask is sampled only on leaving IDLE and at each advance.
module digit_scan_ctrl #(
   parameter int N        = 3,
   parameter int PRESCALE = 100000,
   parameter int BLANK    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   input  logic [2**N-1:0]   digit_mask,
   output logic [N-1:0]      w,
   output logic              en,
   output logic              slot_tick,
   output logic              frame_done
);

   localparam int ND = 2**N;
   localparam int CW = $clog2(PRESCALE);

   localparam logic [CW-1:0] LAST_ON   = CW'(PRESCALE - BLANK - 1);
   localparam logic [CW-1:0] LAST_SLOT = CW'(PRESCALE - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ON    = 2'd1;
   localparam logic [1:0] S_BLANK = 2'd2;

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [N-1:0]  first_idx;
   logic [N-1:0]  next_idx;
   logic [N-1:0]  probe;
   logic          found_first;
   logic          found_next;

   // Lowest set bit of the mask: the digit chosen when leaving IDLE.
   always_comb begin
      first_idx   = '0;
      found_first = 1'b0;
      for (int unsigned i = 0; i < ND; i++) begin
         if (!found_first && digit_mask[i]) begin
            first_idx   = N'(i);
            found_first = 1'b1;
         end
      end
   end

   // First set bit strictly after w, wrapping; offset ND lands back on w itself.
   always_comb begin
      next_idx   = w;
      found_next = 1'b0;
      probe      = '0;
      for (int unsigned k = 1; k <= ND; k++) begin
         probe = w + N'(k);
         if (!found_next && digit_mask[probe]) begin
            next_idx   = probe;
            found_next = 1'b1;
         end
      end
   end

   // Scan state, slot counter and registered decoder outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         w          <= '0;
         en         <= 1'b0;
         slot_tick  <= 1'b0;
         frame_done <= 1'b0;
         cnt        <= '0;
      end else begin
         slot_tick  <= 1'b0;
         frame_done <= 1'b0;
         if (!run) begin
            state <= S_IDLE;
            en    <= 1'b0;
            cnt   <= '0;
         end else begin
            case (state)
               S_IDLE: begin
                  cnt <= '0;
                  if (|digit_mask) begin
                     state     <= S_ON;
                     w         <= first_idx;
                     en        <= 1'b1;
                     slot_tick <= 1'b1;
                  end
               end
               S_ON: begin
                  cnt <= cnt + 1'b1;
                  if (cnt == LAST_ON) begin
                     state <= S_BLANK;
                     en    <= 1'b0;
                  end
               end
               S_BLANK: begin
                  if (cnt == LAST_SLOT) begin
                     cnt <= '0;
                     if (|digit_mask) begin
                        state      <= S_ON;
                        w          <= next_idx;
                        en         <= 1'b1;
                        slot_tick  <= 1'b1;
                        frame_done <= (next_idx <= w);
                     end else begin
                        state <= S_IDLE;
                     end
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               default: begin
                  state <= S_IDLE;
                  en    <= 1'b0;
                  cnt   <= '0;
               end
            endcase
         end
      end
   end

endmodule
